// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the MIPS execute stage.
//   - alusel result classes and aluop codes
//   - divider state enum and iteration count
package ex_pkg;

  localparam int DIV_CYCLES = 32;

  // Result class selected by ID
  localparam logic [2:0] SEL_NOP   = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_ARITH = 3'd3;
  localparam logic [2:0] SEL_MOVE  = 3'd4;

  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_ADDU  = 8'h21;
  localparam logic [7:0] OP_SUB   = 8'h22;
  localparam logic [7:0] OP_SUBU  = 8'h23;
  localparam logic [7:0] OP_SLT   = 8'h2A;
  localparam logic [7:0] OP_SLTU  = 8'h2B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX -> EX -> EX/MEM signal bundle.
//   master: the ID/EX side driving *_i, observing *_o
//   slave : ex_stage
interface ex_stage_if;
  logic [7:0]  ex_aluop_i;
  logic [2:0]  ex_alusel_i;
  logic [31:0] ex_rdata_1_i;
  logic [31:0] ex_rdata_2_i;
  logic [31:0] ex_ext_imm_i;
  logic [4:0]  ex_waddr_i;
  logic        ex_we_i;
  logic        ex_flush_i;
  logic [31:0] ex_wdata_o;
  logic [4:0]  ex_waddr_o;
  logic        ex_we_o;
  logic        ex_stall_req_o;

  modport master (
    output ex_aluop_i, ex_alusel_i, ex_rdata_1_i, ex_rdata_2_i, ex_ext_imm_i,
           ex_waddr_i, ex_we_i, ex_flush_i,
    input  ex_wdata_o, ex_waddr_o, ex_we_o, ex_stall_req_o
  );

  modport slave (
    input  ex_aluop_i, ex_alusel_i, ex_rdata_1_i, ex_rdata_2_i, ex_ext_imm_i,
           ex_waddr_i, ex_we_i, ex_flush_i,
    output ex_wdata_o, ex_waddr_o, ex_we_o, ex_stall_req_o
  );
endinterface

// File: rtl/ex_div.sv
// ex_div: iterative 32-step restoring divider, IDLE/BUSY/DONE.
//   start/signed_op/a/b : divide request (held by the pipeline while busy)
//   flush               : abort, back to IDLE, no done pulse
//   busy                : stall request (IDLE accepting start, or BUSY)
//   done/quot/rem       : sign-corrected result, valid while done is high
module ex_div
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] r_shift, diff;

  always_comb begin
    a_mag   = (signed_op && a[31]) ? (~a + 32'd1) : a;
    b_mag   = (signed_op && b[31]) ? (~b + 32'd1) : b;
    r_shift = {rem_q, dvd_q[31]};
    diff    = r_shift - {1'b0, dvs_q};

    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          busy = 1'b1;
          if (b == 32'd0) begin
            // Divide by zero: fixed result, no sign correction
            dvd_d   = 32'hFFFF_FFFF;
            rem_d   = a;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = DONE;
          end else begin
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = 32'd0;
            cnt_d   = 5'd0;
            qneg_d  = signed_op && (a[31] ^ b[31]);
            rneg_d  = signed_op && a[31];
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        busy = 1'b1;
        // diff[32] set means the trial subtraction went negative: restore
        if (diff[32]) begin
          rem_d = r_shift[31:0];
          dvd_d = {dvd_q[30:0], 1'b0};
        end else begin
          rem_d = diff[31:0];
          dvd_d = {dvd_q[30:0], 1'b1};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      done    = 1'b0;
    end
  end

  assign quot = qneg_q ? (~dvd_q + 32'd1) : dvd_q;
  assign rem  = rneg_q ? (~rem_q + 32'd1) : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      dvd_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. Combinational logic/shift/arith/move
// results, architectural HI/LO, MULT/MULTU, and optional divider.
//   clk, rst : clock, async active-high reset (outputs forced to 0)
//   bus      : ex_stage_if.slave (ID/EX inputs, EX/MEM outputs, stall)
// Build option: EX_DIV_EN enables DIV/DIVU via ex_div and the stall
// request; without it DIV/DIVU behave as NOP and stall is tied low.
module ex_stage
  import ex_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus
);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a, b, wdata;
  logic [4:0]  shamt;
  logic        we;
  logic [31:0] sum, dif;
  logic [63:0] prod_s, prod_u;
  logic        is_div;
  logic        div_busy, div_done;
  logic [31:0] div_quot, div_rem;

  assign a      = bus.ex_rdata_1_i;
  assign b      = bus.ex_rdata_2_i;
  assign shamt  = bus.ex_ext_imm_i[10:6];
  assign sum    = a + b;
  assign dif    = a - b;
  assign prod_s = $signed(a) * $signed(b);
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign is_div = (bus.ex_aluop_i == OP_DIV) || (bus.ex_aluop_i == OP_DIVU);

`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
  ex_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (is_div),
    .signed_op(bus.ex_aluop_i == OP_DIV),
    .a        (a),
    .b        (b),
    .flush    (bus.ex_flush_i),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );
`else
  localparam bit DIV_EN = 1'b0;
  assign div_busy = 1'b0;
  assign div_done = 1'b0;
  assign div_quot = 32'd0;
  assign div_rem  = 32'd0;
`endif

  always_comb begin
    wdata = 32'd0;
    we    = bus.ex_we_i;
    hi_d  = hi_q;
    lo_d  = lo_q;

    case (bus.ex_alusel_i)
      SEL_LOGIC: begin
        case (bus.ex_aluop_i)
          OP_AND:  wdata = a & b;
          OP_OR:   wdata = a | b;
          OP_XOR:  wdata = a ^ b;
          OP_NOR:  wdata = ~(a | b);
          default: wdata = 32'd0;
        endcase
      end
      SEL_SHIFT: begin
        case (bus.ex_aluop_i)
          OP_SLL:  wdata = b << shamt;
          OP_SRL:  wdata = b >> shamt;
          OP_SRA:  wdata = $unsigned($signed(b) >>> shamt);
          default: wdata = 32'd0;
        endcase
      end
      SEL_ARITH: begin
        case (bus.ex_aluop_i)
          OP_ADD: begin
            wdata = sum;
            if ((a[31] == b[31]) && (sum[31] != a[31])) we = 1'b0;
          end
          OP_ADDU: wdata = sum;
          OP_SUB: begin
            wdata = dif;
            if ((a[31] != b[31]) && (dif[31] != a[31])) we = 1'b0;
          end
          OP_SUBU: wdata = dif;
          OP_SLT:  wdata = {31'd0, $signed(a) < $signed(b)};
          OP_SLTU: wdata = {31'd0, a < b};
          default: wdata = 32'd0;
        endcase
      end
      SEL_MOVE: begin
        case (bus.ex_aluop_i)
          OP_MFHI: wdata = hi_q;
          OP_MFLO: wdata = lo_q;
          default: wdata = 32'd0;
        endcase
      end
      default: wdata = 32'd0;
    endcase

    // HI/LO-only ops are keyed on aluop alone and never write the GPR file
    case (bus.ex_aluop_i)
      OP_MTHI:  begin hi_d = a; wdata = 32'd0; we = 1'b0; end
      OP_MTLO:  begin lo_d = a; wdata = 32'd0; we = 1'b0; end
      OP_MULT:  begin {hi_d, lo_d} = prod_s; wdata = 32'd0; we = 1'b0; end
      OP_MULTU: begin {hi_d, lo_d} = prod_u; wdata = 32'd0; we = 1'b0; end
      default: ;
    endcase

    if (DIV_EN && is_div) begin
      wdata = 32'd0;
      we    = 1'b0;
      if (div_done) begin
        hi_d = div_rem;
        lo_d = div_quot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.ex_wdata_o     = rst ? 32'd0 : wdata;
  assign bus.ex_waddr_o     = rst ? 5'd0  : bus.ex_waddr_i;
  assign bus.ex_we_o        = rst ? 1'b0  : we;
  assign bus.ex_stall_req_o = rst ? 1'b0  : div_busy;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage. Divider cases run when
// EX_DIV_EN is defined; otherwise DIV is checked to behave as a NOP.
module tb_ex_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errs = 0;
  int   checks = 0;

  ex_stage_if bus ();

  ex_stage u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] ra, input logic [31:0] rb,
                       input logic [31:0] imm, input logic we);
    bus.ex_aluop_i   = op;
    bus.ex_alusel_i  = sel;
    bus.ex_rdata_1_i = ra;
    bus.ex_rdata_2_i = rb;
    bus.ex_ext_imm_i = imm;
    bus.ex_we_i      = we;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

`ifdef EX_DIV_EN
  // count stall cycles from the issue cycle; leaves us in the first non-stall cycle
  task automatic count_stall(output int n);
    n = 0;
    sample();
    while (bus.ex_stall_req_o && n < 100) begin
      n++;
      tick();
      sample();
    end
  endtask
`endif

  initial begin
    int n;
    rst = 1'b1;
    bus.ex_flush_i = 1'b0;
    bus.ex_waddr_i = 5'd3;
    drive(OP_OR, SEL_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 1'b1);
    sample();
    chk("rst_wdata", bus.ex_wdata_o, 32'd0);
    chk("rst_we",    {31'd0, bus.ex_we_o}, 32'd0);
    chk("rst_stall", {31'd0, bus.ex_stall_req_o}, 32'd0);
    chk("rst_waddr", {27'd0, bus.ex_waddr_o}, 32'd0);
    tick(); rst = 1'b0;

    sample();
    chk("or_wdata", bus.ex_wdata_o, 32'hF0F0_0F0F);
    chk("or_we",    {31'd0, bus.ex_we_o}, 32'd1);
    chk("waddr",    {27'd0, bus.ex_waddr_o}, 32'd3);

    tick(); drive(OP_NOR, SEL_LOGIC, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("nor", bus.ex_wdata_o, 32'hFFFF_FFFF);
    tick(); drive(OP_SRA, SEL_SHIFT, 32'd0, 32'h8000_0000, 32'd4 << 6, 1'b1);
    sample(); chk("sra", bus.ex_wdata_o, 32'hF800_0000);
    tick(); drive(OP_SRL, SEL_SHIFT, 32'd0, 32'h8000_0000, 32'd4 << 6, 1'b1);
    sample(); chk("srl", bus.ex_wdata_o, 32'h0800_0000);
    tick(); drive(OP_SLL, SEL_SHIFT, 32'd0, 32'd1, 32'd31 << 6, 1'b1);
    sample(); chk("sll", bus.ex_wdata_o, 32'h8000_0000);

    tick(); drive(OP_ADD, SEL_ARITH, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1);
    sample(); chk("add_ovf_we", {31'd0, bus.ex_we_o}, 32'd0);
    tick(); drive(OP_ADDU, SEL_ARITH, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1);
    sample(); chk("addu", bus.ex_wdata_o, 32'h8000_0000);
    chk("addu_we", {31'd0, bus.ex_we_o}, 32'd1);
    tick(); drive(OP_SUB, SEL_ARITH, 32'd5, 32'd7, 32'd0, 1'b1);
    sample(); chk("sub", bus.ex_wdata_o, 32'hFFFF_FFFE);
    chk("sub_we", {31'd0, bus.ex_we_o}, 32'd1);
    tick(); drive(OP_SUB, SEL_ARITH, 32'h8000_0000, 32'd1, 32'd0, 1'b1);
    sample(); chk("sub_ovf_we", {31'd0, bus.ex_we_o}, 32'd0);
    tick(); drive(OP_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    sample(); chk("slt", bus.ex_wdata_o, 32'd1);
    tick(); drive(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    sample(); chk("sltu", bus.ex_wdata_o, 32'd0);

    tick(); drive(OP_MULT, SEL_NOP, 32'hFFFF_FFFD, 32'd5, 32'd0, 1'b1);
    sample(); chk("mult_wdata", bus.ex_wdata_o, 32'd0);
    chk("mult_we", {31'd0, bus.ex_we_o}, 32'd0);
    tick(); drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("mult_lo", bus.ex_wdata_o, 32'hFFFF_FFF1);
    tick(); drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("mult_hi", bus.ex_wdata_o, 32'hFFFF_FFFF);
    tick(); drive(OP_MULTU, SEL_NOP, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b1);
    tick(); drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("multu_hi", bus.ex_wdata_o, 32'd1);

    tick(); drive(OP_MTHI, SEL_MOVE, 32'h1234_5678, 32'd0, 32'd0, 1'b1);
    sample(); chk("mthi_we", {31'd0, bus.ex_we_o}, 32'd0);
    tick(); drive(OP_MTLO, SEL_MOVE, 32'h8765_4321, 32'd0, 32'd0, 1'b1);
    tick(); drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("mthi", bus.ex_wdata_o, 32'h1234_5678);
    tick(); drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("mtlo", bus.ex_wdata_o, 32'h8765_4321);

    tick(); drive(8'hEE, SEL_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
    sample(); chk("unk_wdata", bus.ex_wdata_o, 32'd0);
    chk("unk_we", {31'd0, bus.ex_we_o}, 32'd1);

`ifdef EX_DIV_EN
    // signed divide -7 / 2
    tick(); drive(OP_DIV, SEL_NOP, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
    count_stall(n);
    chk("div_stall_cycles", n, 32'd33);
    tick(); drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("div_lo", bus.ex_wdata_o, 32'hFFFF_FFFD);
    tick(); drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("div_hi", bus.ex_wdata_o, 32'hFFFF_FFFF);

    // unsigned 100 / 0
    tick(); drive(OP_DIVU, SEL_NOP, 32'd100, 32'd0, 32'd0, 1'b0);
    count_stall(n);
    chk("div0_stall_cycles", n, 32'd1);
    tick(); drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("div0_hi", bus.ex_wdata_o, 32'd100);
    tick(); drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("div0_lo", bus.ex_wdata_o, 32'hFFFF_FFFF);

    // flush in BUSY cycle 10
    tick(); drive(OP_DIVU, SEL_NOP, 32'd50, 32'd3, 32'd0, 1'b0);
    sample(); chk("fl_issue_stall", {31'd0, bus.ex_stall_req_o}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    bus.ex_flush_i = 1'b1;
    sample(); chk("fl_busy_stall", {31'd0, bus.ex_stall_req_o}, 32'd1);
    tick(); bus.ex_flush_i = 1'b0;
    drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("fl_stall_drop", {31'd0, bus.ex_stall_req_o}, 32'd0);
    chk("fl_hi", bus.ex_wdata_o, 32'd100);
    tick(); drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("fl_lo", bus.ex_wdata_o, 32'hFFFF_FFFF);

    // reset mid-divide
    tick(); drive(OP_DIV, SEL_NOP, 32'd50, 32'd3, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    sample(); chk("rd_busy", {31'd0, bus.ex_stall_req_o}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("rd_stall", {31'd0, bus.ex_stall_req_o}, 32'd0);
    drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    tick(); rst = 1'b0;
    sample(); chk("rd_hi", bus.ex_wdata_o, 32'd0);
    chk("rd_idle", {31'd0, bus.ex_stall_req_o}, 32'd0);
    tick(); drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("rd_lo", bus.ex_wdata_o, 32'd0);
`else
    // divider absent: DIV is a NOP
    tick(); drive(OP_DIV, SEL_NOP, 32'd10, 32'd2, 32'd0, 1'b1);
    sample(); chk("nodiv_stall", {31'd0, bus.ex_stall_req_o}, 32'd0);
    chk("nodiv_wdata", bus.ex_wdata_o, 32'd0);
    chk("nodiv_we", {31'd0, bus.ex_we_o}, 32'd1);
    tick(); sample(); chk("nodiv_stall2", {31'd0, bus.ex_stall_req_o}, 32'd0);
    tick(); drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("nodiv_hi", bus.ex_wdata_o, 32'h1234_5678);
    tick(); drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 32'd0, 1'b1);
    sample(); chk("nodiv_lo", bus.ex_wdata_o, 32'h8765_4321);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
